// File: rtl/stride_serializer_pkg.sv
// rtl/stride_serializer_pkg.sv - shared stride geometry, types and helpers
package stride_serializer_pkg;

    localparam int CHAR_SIZE   = 8;
    localparam int STRIDE_SIZE = 8;
    localparam int WORD_SIZE   = 32;
    localparam int NUM_STRIDES = WORD_SIZE / STRIDE_SIZE;
    localparam int LEN_W       = $clog2(STRIDE_SIZE + 1);
    localparam int CNT_W       = $clog2(NUM_STRIDES + 1);
    localparam int IDX_W       = $clog2(NUM_STRIDES);
    localparam int CHR_W       = $clog2(STRIDE_SIZE);

    localparam logic [CHAR_SIZE-1:0] DEFAULT_CHAR = 8'h00;

    typedef logic [STRIDE_SIZE-1:0][CHAR_SIZE-1:0] stride_t;
    typedef logic [LEN_W-1:0]                      stride_len_t;
    typedef stride_t     [NUM_STRIDES-1:0]         stride_buf_t;
    typedef stride_len_t [NUM_STRIDES-1:0]         len_vec_t;

    localparam stride_len_t        MAX_LEN = LEN_W'(STRIDE_SIZE);
    localparam logic [CNT_W-1:0]   MAX_CNT = CNT_W'(NUM_STRIDES);

    typedef enum logic {
        S_IDLE,
        S_EMIT
    } ser_state_t;

    // Index of the highest non-empty stride below count; 0 when none exists.
    function automatic logic [IDX_W-1:0] last_nonempty(input len_vec_t lens,
                                                       input logic [CNT_W-1:0] count);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_STRIDES; i++) begin
            if (CNT_W'(i) < count && lens[i] != '0) begin
                r = IDX_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/stride_next_finder.sv
// rtl/stride_next_finder.sv - finds the first non-empty stride at or after start_idx
// start_idx : first candidate stride index
// lens      : clamped per-stride lengths
// count     : clamped number of valid strides
// next_idx  : lowest index >= start_idx, < count, with non-zero length
// none_left : no such stride exists
module stride_next_finder
    import stride_serializer_pkg::*;
(
    input  logic [CNT_W-1:0] start_idx,
    input  len_vec_t         lens,
    input  logic [CNT_W-1:0] count,
    output logic [IDX_W-1:0] next_idx,
    output logic             none_left
);

    // Scan downwards so the lowest qualifying index is the one left standing.
    always_comb begin
        next_idx  = '0;
        none_left = 1'b1;
        for (int i = NUM_STRIDES - 1; i >= 0; i--) begin
            if (CNT_W'(i) >= start_idx && CNT_W'(i) < count && lens[i] != '0) begin
                next_idx  = IDX_W'(i);
                none_left = 1'b0;
            end
        end
    end

endmodule

// File: rtl/stride_serializer.sv
// rtl/stride_serializer.sv - rebuilds an ASCII name from a stride collection, one char per cycle
// clk, rst                    : clock, synchronous active-high reset
// strideValid/strideReady     : collection load handshake
// strideData/strideLen/strideCount : stride chars, per-stride lengths, stride count
// charValid/charReady         : output char handshake
// outChar, charLast           : current char, final-char flag
// busy                        : a collection is held and not fully emitted
module stride_serializer
    import stride_serializer_pkg::*;
(
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        strideValid,
    output logic                                        strideReady,
    input  logic [NUM_STRIDES*STRIDE_SIZE*CHAR_SIZE-1:0] strideData,
    input  logic [NUM_STRIDES*LEN_W-1:0]                strideLen,
    input  logic [CNT_W-1:0]                            strideCount,
    output logic                                        charValid,
    input  logic                                        charReady,
    output logic [CHAR_SIZE-1:0]                        outChar,
    output logic                                        charLast,
    output logic                                        busy
);

    ser_state_t           state_q,     state_d;
    stride_buf_t          buf_q,       buf_d;
    len_vec_t             lens_q,      lens_d;
    logic [CNT_W-1:0]     cnt_q,       cnt_d;
    logic [IDX_W-1:0]     last_idx_q,  last_idx_d;
    logic [IDX_W-1:0]     stride_idx_q, stride_idx_d;
    logic [CHR_W-1:0]     char_idx_q,  char_idx_d;
    logic                 ready_q,     ready_d;
    logic                 busy_q,      busy_d;
    logic                 valid_q,     valid_d;
    logic                 last_q,      last_d;
    logic [CHAR_SIZE-1:0] out_char_q,  out_char_d;

    len_vec_t             lens_in;
    logic [CNT_W-1:0]     count_in;
    logic [IDX_W-1:0]     load_idx;
    logic                 load_none;
    logic [IDX_W-1:0]     next_idx;
    logic                 next_none;

    always_comb begin
        for (int i = 0; i < NUM_STRIDES; i++) begin
            lens_in[i] = (strideLen[i*LEN_W +: LEN_W] > MAX_LEN) ? MAX_LEN
                                                                 : strideLen[i*LEN_W +: LEN_W];
        end
        count_in = (strideCount > MAX_CNT) ? MAX_CNT : strideCount;
    end

    // First non-empty stride of an incoming collection.
    stride_next_finder u_load_finder (
        .start_idx (CNT_W'(0)),
        .lens      (lens_in),
        .count     (count_in),
        .next_idx  (load_idx),
        .none_left (load_none)
    );

    // Next non-empty stride after the one currently being emitted.
    stride_next_finder u_next_finder (
        .start_idx (CNT_W'(stride_idx_q) + CNT_W'(1)),
        .lens      (lens_q),
        .count     (cnt_q),
        .next_idx  (next_idx),
        .none_left (next_none)
    );

    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        lens_d       = lens_q;
        cnt_d        = cnt_q;
        last_idx_d   = last_idx_q;
        stride_idx_d = stride_idx_q;
        char_idx_d   = char_idx_q;
        ready_d      = ready_q;
        busy_d       = busy_q;
        valid_d      = valid_q;

        case (state_q)
            S_IDLE: begin
                if (strideValid) begin
                    buf_d      = strideData;
                    lens_d     = lens_in;
                    cnt_d      = count_in;
                    last_idx_d = last_nonempty(lens_in, count_in);
                    if (!load_none) begin
                        state_d      = S_EMIT;
                        ready_d      = 1'b0;
                        busy_d       = 1'b1;
                        valid_d      = 1'b1;
                        stride_idx_d = load_idx;
                        char_idx_d   = '0;
                    end
                end
            end
            S_EMIT: begin
                if (valid_q && charReady) begin
                    if (last_q) begin
                        state_d = S_IDLE;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                        valid_d = 1'b0;
                    end else if (LEN_W'(char_idx_q) + LEN_W'(1) < lens_q[stride_idx_q]) begin
                        char_idx_d = char_idx_q + CHR_W'(1);
                    end else if (!next_none) begin
                        stride_idx_d = next_idx;
                        char_idx_d   = '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Output regs are recomputed from the next pointer, so they stay put while stalled.
        if (valid_d) begin
            out_char_d = buf_d[stride_idx_d][char_idx_d];
            last_d     = (stride_idx_d == last_idx_d) &&
                         (LEN_W'(char_idx_d) + LEN_W'(1) == lens_d[stride_idx_d]);
        end else begin
            out_char_d = DEFAULT_CHAR;
            last_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            buf_q        <= '0;
            lens_q       <= '0;
            cnt_q        <= '0;
            last_idx_q   <= '0;
            stride_idx_q <= '0;
            char_idx_q   <= '0;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
            valid_q      <= 1'b0;
            last_q       <= 1'b0;
            out_char_q   <= DEFAULT_CHAR;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            lens_q       <= lens_d;
            cnt_q        <= cnt_d;
            last_idx_q   <= last_idx_d;
            stride_idx_q <= stride_idx_d;
            char_idx_q   <= char_idx_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            valid_q      <= valid_d;
            last_q       <= last_d;
            out_char_q   <= out_char_d;
        end
    end

    // Held low while rst is asserted so no load can be offered during reset.
    assign strideReady = ready_q & ~rst;
    assign charValid   = valid_q;
    assign outChar     = out_char_q;
    assign charLast    = last_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_stride_serializer.sv
// tb/tb_stride_serializer.sv - self-checking bench for stride_serializer
module tb_stride_serializer;
    import stride_serializer_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         strideValid;
    logic         strideReady;
    logic [255:0] strideData;
    logic [15:0]  strideLen;
    logic [2:0]   strideCount;
    logic         charValid;
    logic         charReady;
    logic [7:0]   outChar;
    logic         charLast;
    logic         busy;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] c;
        logic       l;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic [255:0] data;
        logic [15:0]  lens;
        logic [2:0]   cnt;
        logic [255:0] name;
        int           nlen;
        int           mode;
        bit           inject;
    } vec_t;

    vec_t vecs[11];

    stride_serializer dut (
        .clk         (clk),
        .rst         (rst),
        .strideValid (strideValid),
        .strideReady (strideReady),
        .strideData  (strideData),
        .strideLen   (strideLen),
        .strideCount (strideCount),
        .charValid   (charValid),
        .charReady   (charReady),
        .outChar     (outChar),
        .charLast    (charLast),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] mk_data(input string s0, input string s1,
                                             input string s2, input string s3);
        logic [255:0] d;
        string        s;
        d = {32{8'hEE}};
        for (int i = 0; i < 4; i++) begin
            s = (i == 0) ? s0 : (i == 1) ? s1 : (i == 2) ? s2 : s3;
            for (int j = 0; j < s.len() && j < 8; j++) begin
                d[(i*8+j)*8 +: 8] = s.getc(j);
            end
        end
        return d;
    endfunction

    function automatic logic [255:0] mk_name(input string s);
        logic [255:0] d;
        d = '0;
        for (int k = 0; k < s.len() && k < 32; k++) begin
            d[k*8 +: 8] = s.getc(k);
        end
        return d;
    endfunction

    function automatic logic [15:0] mk_lens(input int a, input int b, input int c, input int d);
        logic [3:0] la, lb, lc, ld;
        la = 4'(a); lb = 4'(b); lc = 4'(c); ld = 4'(d);
        return {ld, lc, lb, la};
    endfunction

    function automatic vec_t mk_vec(input logic [255:0] data, input logic [15:0] lens,
                                    input int cnt, input string name, input int mode,
                                    input bit inject);
        vec_t v;
        v.data   = data;
        v.lens   = lens;
        v.cnt    = 3'(cnt);
        v.name   = mk_name(name);
        v.nlen   = name.len();
        v.mode   = mode;
        v.inject = inject;
        return v;
    endfunction

    function automatic bit ready_pattern(input int mode, input int cyc);
        case (mode)
            0:       return 1'b1;
            1:       return (cyc % 3) == 0;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        int          cyc;
        int          got;
        int          w;
        bit          stalled;
        bit          r;
        logic [7:0]  held_c;
        logic        held_l;
        exp_t        e;

        w = 0;
        while (!strideReady && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk($sformatf("v%0d ready before load", idx), strideReady, 1);

        for (int k = 0; k < v.nlen; k++) begin
            e.c = v.name[k*8 +: 8];
            e.l = (k == v.nlen - 1);
            sb.push_back(e);
        end
        strideData  = v.data;
        strideLen   = v.lens;
        strideCount = v.cnt;
        strideValid = 1'b1;
        charReady   = 1'b0;
        @(negedge clk);
        strideValid = 1'b0;

        if (v.nlen == 0) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("v%0d empty valid", idx), charValid, 0);
                chk($sformatf("v%0d empty ready", idx), strideReady, 1);
                @(negedge clk);
            end
            return;
        end

        chk($sformatf("v%0d first valid latency", idx), charValid, 1);
        cyc = 0;
        got = 0;
        stalled = 0;
        held_c = '0;
        held_l = 1'b0;
        while (got < v.nlen && cyc < 400) begin
            if (stalled) begin
                chk($sformatf("v%0d held char", idx), outChar, held_c);
                chk($sformatf("v%0d held last", idx), charLast, held_l);
                chk($sformatf("v%0d held valid", idx), charValid, 1);
            end
            r = ready_pattern(v.mode, cyc);
            charReady = r;
            strideValid = v.inject && (cyc == 2);
            if (v.inject && cyc == 2) begin
                strideData  = '1;
                strideLen   = mk_lens(8, 8, 8, 8);
                strideCount = 3'd4;
            end
            if (charValid) begin
                chk($sformatf("v%0d busy", idx), busy, 1);
            end
            if (charValid && r) begin
                if (sb.size() == 0) begin
                    chk($sformatf("v%0d spurious char", idx), 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("v%0d char %0d", idx, got), outChar, e.c);
                    chk($sformatf("v%0d last %0d", idx, got), charLast, e.l);
                end
                got++;
            end
            stalled = charValid && !r;
            held_c  = outChar;
            held_l  = charLast;
            cyc++;
            @(negedge clk);
        end
        strideValid = 1'b0;
        charReady   = 1'b0;
        chk($sformatf("v%0d handshake count", idx), got, v.nlen);
        if (got < v.nlen) begin
            sb.delete();
        end
        if (v.mode == 0) begin
            chk($sformatf("v%0d no bubbles", idx), cyc, v.nlen);
        end
        chk($sformatf("v%0d idle valid", idx), charValid, 0);
        chk($sformatf("v%0d idle busy", idx), busy, 0);
        chk($sformatf("v%0d idle ready", idx), strideReady, 1);
    endtask

    initial begin
        vecs[0]  = mk_vec(mk_data("/a", "/bc", "", ""), mk_lens(2, 3, 0, 0), 2, "/a/bc", 0, 0);
        vecs[1]  = mk_vec(mk_data("/a", "/bc", "", ""), mk_lens(2, 3, 0, 0), 2, "/a/bc", 1, 0);
        vecs[2]  = mk_vec(mk_data("/a", "xx", "/bc", ""), mk_lens(2, 0, 3, 0), 3, "/a/bc", 0, 0);
        vecs[3]  = mk_vec(mk_data("/a", "/bc", "", ""), mk_lens(2, 3, 0, 0), 0, "", 0, 0);
        vecs[4]  = mk_vec(mk_data("/abcdefg", "", "", ""), mk_lens(9, 0, 0, 0), 1, "/abcdefg", 0, 0);
        vecs[5]  = mk_vec(mk_data("/0123456", "/789abcd", "/efghijk", "/lmnopqr"), mk_lens(8, 8, 8, 8), 4,
                          "/0123456/789abcd/efghijk/lmnopqr", 0, 1);
        vecs[6]  = mk_vec(mk_data("/0123456", "/789abcd", "/efghijk", "/lmnopqr"), mk_lens(8, 8, 8, 8), 4,
                          "/0123456/789abcd/efghijk/lmnopqr", 2, 0);
        vecs[7]  = mk_vec(mk_data("/", "a", "/", "b"), mk_lens(1, 1, 1, 1), 7, "/a/b", 1, 0);
        vecs[8]  = mk_vec(mk_data("/a", "/bc", "/de", ""), mk_lens(2, 3, 3, 0), 2, "/a/bc", 2, 0);
        vecs[9]  = mk_vec(mk_data("zz", "/a", "yy", "/bc"), mk_lens(0, 2, 0, 3), 4, "/a/bc", 0, 0);
        vecs[10] = mk_vec(mk_data("/a", "/b", "/c", ""), mk_lens(0, 0, 0, 0), 3, "", 0, 0);

        rst = 1'b1;
        strideValid = 1'b0;
        strideData = '0;
        strideLen = '0;
        strideCount = '0;
        charReady = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset strideReady", strideReady, 0);
        chk("reset charValid", charValid, 0);
        chk("reset outChar", outChar, 8'h00);
        chk("reset charLast", charLast, 0);
        chk("reset busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post-reset strideReady", strideReady, 1);

        for (int i = 0; i < 11; i++) begin
            run_vec(i, vecs[i]);
        end

        // Reset in the middle of a name, then a fresh load.
        strideData  = mk_data("/0123456", "/789abcd", "/efghijk", "/lmnopqr");
        strideLen   = mk_lens(8, 8, 8, 8);
        strideCount = 3'd4;
        strideValid = 1'b1;
        @(negedge clk);
        strideValid = 1'b0;
        charReady   = 1'b1;
        chk("mid-rst char0", outChar, 8'h2f);
        @(negedge clk);
        chk("mid-rst char1", outChar, 8'h30);
        @(negedge clk);
        charReady = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("mid-rst valid", charValid, 0);
        chk("mid-rst busy", busy, 0);
        chk("mid-rst last", charLast, 0);
        chk("mid-rst strideReady", strideReady, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("mid-rst ready after release", strideReady, 1);
        run_vec(20, vecs[0]);

        // rst and strideValid together: nothing is loaded.
        rst = 1'b1;
        strideData  = vecs[0].data;
        strideLen   = vecs[0].lens;
        strideCount = vecs[0].cnt;
        strideValid = 1'b1;
        @(negedge clk);
        strideValid = 1'b0;
        rst = 1'b0;
        chk("rst+load valid", charValid, 0);
        chk("rst+load busy", busy, 0);
        @(negedge clk);
        chk("rst+load valid after", charValid, 0);
        chk("rst+load ready after", strideReady, 1);
        chk("rst+load busy after", busy, 0);
        run_vec(21, vecs[2]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stride_serializer.md
Name: stride_serializer

Overview:
- Inverse of the name-to-stride converter: accepts one complete stride collection (up to NUM_STRIDES strides of up to STRIDE_SIZE chars) per load handshake.
- Emits the original ASCII name one char per cycle on a valid/ready stream, with a last flag on the final char.
- Sits on the NDN lookup output side, where it rebuilds names from stored or forwarded stride collections for logging, forwarding, or comparison.

Parameters:
- CHAR_SIZE, 8, bits per char.
- STRIDE_SIZE, 8, max chars per stride.
- NUM_STRIDES, 4, max strides per name (equals WORD_SIZE/STRIDE_SIZE).
- LEN_W, $clog2(STRIDE_SIZE+1) = 4, width of one stride length field.
- CNT_W, $clog2(NUM_STRIDES+1) = 3, width of the stride count.

Ports:
- clk  input  1  clock, all logic on posedge.
- rst  input  1  synchronous active-high reset.
- strideValid  input  1  load request.
- strideReady  output  1  block can accept a collection.
- strideData  input  NUM_STRIDES*STRIDE_SIZE*CHAR_SIZE  char j of stride i at [(i*STRIDE_SIZE+j)*CHAR_SIZE +: CHAR_SIZE].
- strideLen  input  NUM_STRIDES*LEN_W  length of stride i at [i*LEN_W +: LEN_W].
- strideCount  input  CNT_W  number of valid strides.
- charValid  output  1  outChar valid.
- charReady  input  1  downstream accepts char.
- outChar  output  CHAR_SIZE  current char.
- charLast  output  1  final char of the name.
- busy  output  1  collection held, not yet fully emitted.

Behaviour:
- Reset: rst is synchronous, active-high, and sampled on the posedge of clk.
  - Reset values: strideReady=0 during reset and 1 in the first cycle after. charValid=0, outChar=8'h00, charLast=0, busy=0.
  - Internal indices are cleared and the buffer is discarded.
- FSM has two states:
  - IDLE: strideReady=1.
  - EMIT: strideReady=0, busy=1.
- Load (IDLE, strideValid=1):
  - Register strideData into an internal buffer. Register per-stride lengths clamped to min(len, STRIDE_SIZE). Register the count clamped to min(count, NUM_STRIDES).
  - If the total clamped length (sum over strides < count) is 0, stay in IDLE and emit nothing.
  - Otherwise go to EMIT with indices pointing to the first char of the first non-empty stride.
- Output timing:
  - The first char is presented with charValid=1 in the cycle after load; latency is 1.
  - outChar, charValid, and charLast are registered and held stable while charValid=1 and charReady=0.
- Advance on a charValid && charReady handshake:
  - Increment the char index. At the end of the current stride's length, move to the next stride with length > 0.
  - Zero-length strides are skipped with no bubble; throughput is 1 char/cycle under continuous ready.
- charLast is 1 exactly on the final char of the last non-empty stride below count.
  - A handshake on that char returns to IDLE: charValid=0, busy=0, strideReady=1 next cycle. This leaves one bubble between names.
- Chars are emitted verbatim, including '/' and any 8'h00 inside a stated length. No delimiter is inserted; the strides already carry their leading '/'.
- strideValid while in EMIT is ignored; there is no queuing.
- Reset mid-EMIT aborts immediately. No charLast is emitted for the truncated name.
- Simultaneous rst and strideValid: rst wins and nothing is loaded.

Decomposition:
- Shared package holds:
  - CHAR_SIZE, STRIDE_SIZE, WORD_SIZE, NUM_STRIDES, DEFAULT_CHAR (8'h00).
  - A stride_t typedef (STRIDE_SIZE x CHAR_SIZE).
  - A stride_len_t typedef (LEN_W).
  - This is the same package the converter imports.
- One natural sub-module: stride_next_finder, combinational. It takes the current stride index, clamped lengths, and count, and returns the next non-empty stride index plus a none-left flag. It is used both at load time and at stride boundaries.

Test Plan:
- Basic name "/a/bc": strides {"/a","/bc"}, lens {2,3}, count=2, charReady=1 -> '/','a','/','b','c' on 5 consecutive cycles starting 1 cycle after load; charLast only on 'c'; strideReady=1 the cycle after.
- Backpressure: same load with charReady toggling 1,0,0,1,... -> every char is held stable while stalled; exactly 5 handshakes in order; charLast on 'c'.
- Zero-length skip: count=3, lens {2,0,3} -> 5 chars with no gap between 'a' and the third stride's first char.
- Empty/clamp: count=0 -> no charValid and strideReady stays 1. Separately, len=9 with count=1 -> exactly 8 chars emitted.
- Full name: 4 strides of 8 -> 32 chars, charLast on the 32nd only.
- Reset mid-stream: assert rst after the 2nd handshake -> next cycle charValid=0, busy=0; after release, a new load emits correctly from its first char.
